// File: rtl/sseg_pkg.sv
// +------------------------------------------------------------------+
// | sseg_pkg : shared constants and scan-state type for sseg_scan_mux |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package sseg_pkg;

    localparam int         NUM_DIGITS      = 16;
    localparam logic [4:0] ADDR_DAY_DUTY   = 5'd16;
    localparam logic [4:0] ADDR_NIGHT_DUTY = 5'd17;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_LIT   = 1'b1
    } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +------------------------------------------------------------------+
// | sync_2ff : single-bit two-flop synchronizer, async reset to 0     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/sseg_scan_mux.sv
// +------------------------------------------------------------------+
// | sseg_scan_mux : 16-digit multiplexed 7-seg driver, Avalon-MM slave |
// | with blank gap and PWM brightness. SSEG_BRIGHTNESS_REG_EN makes    |
// | the day/night duty writable at addresses 16/17.                    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 3125,
    parameter int unsigned BLANK_CYCLES = 50,
    parameter logic [7:0]  DAY_DUTY     = 8'd255,
    parameter logic [7:0]  NIGHT_DUTY   = 8'd48
) (
    input  logic        clock_50_clk,
    input  logic        reset_reset_n,
    input  logic [4:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_write,
    input  logic        avs_read,
    input  logic [7:0]  avs_writedata,
    output logic [7:0]  avs_readdata,
    input  logic        daylight,
    output logic [7:0]  sseg,
    output logic [15:0] digit_sel
);

    localparam logic [12:0] C_DWELL = 13'(DWELL_CYCLES);

    logic [7:0]  pat_q [NUM_DIGITS];
    logic [7:0]  avs_readdata_q;
    logic [7:0]  w_rd_mux;
    logic        w_wr_en;
    logic        w_day_sync;
    logic [7:0]  w_day_duty;
    logic [7:0]  w_night_duty;
    logic [7:0]  w_duty;
    logic [20:0] w_prod;
    logic [12:0] w_on_cycles;

    scan_state_e state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  lat_pat_q, lat_pat_d;
    logic [12:0] on_q, on_d;
    logic [7:0]  sseg_q, sseg_d;
    logic [15:0] digit_sel_q, digit_sel_d;

    assign w_wr_en = avs_chipselect && avs_write;

    sync_2ff u_day_sync (
        .clk_i  (clock_50_clk),
        .rst_ni (reset_reset_n),
        .d_i    (daylight),
        .q_o    (w_day_sync)
    );

    always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pat_q[i] <= '0;
            end
        end else if (w_wr_en && !avs_address[4]) begin
            pat_q[avs_address[3:0]] <= avs_writedata;
        end
    end

`ifdef SSEG_BRIGHTNESS_REG_EN
    logic [7:0] day_duty_q;
    logic [7:0] night_duty_q;

    always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            day_duty_q   <= DAY_DUTY;
            night_duty_q <= NIGHT_DUTY;
        end else if (w_wr_en) begin
            if (avs_address == ADDR_DAY_DUTY) begin
                day_duty_q <= avs_writedata;
            end
            if (avs_address == ADDR_NIGHT_DUTY) begin
                night_duty_q <= avs_writedata;
            end
        end
    end

    assign w_day_duty   = day_duty_q;
    assign w_night_duty = night_duty_q;
`else
    assign w_day_duty   = DAY_DUTY;
    assign w_night_duty = NIGHT_DUTY;
`endif

    always_comb begin
        w_rd_mux = '0;
        if (!avs_address[4]) begin
            w_rd_mux = pat_q[avs_address[3:0]];
        end
`ifdef SSEG_BRIGHTNESS_REG_EN
        if (avs_address == ADDR_DAY_DUTY) begin
            w_rd_mux = w_day_duty;
        end
        if (avs_address == ADDR_NIGHT_DUTY) begin
            w_rd_mux = w_night_duty;
        end
`endif
    end

    // Read samples the array before any same-edge write lands, so a
    // colliding read returns the old value.
    always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata_q <= '0;
        end else if (avs_chipselect && avs_read) begin
            avs_readdata_q <= w_rd_mux;
        end
    end

    assign w_duty      = w_day_sync ? w_day_duty : w_night_duty;
    assign w_prod      = 21'(w_duty) * 21'(C_DWELL);
    assign w_on_cycles = 13'(w_prod >> 8);

    always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= S_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            lat_pat_q   <= '0;
            on_q        <= '0;
            sseg_q      <= '0;
            digit_sel_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            lat_pat_q   <= lat_pat_d;
            on_q        <= on_d;
            sseg_q      <= sseg_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 13'd1;
        idx_d       = idx_q;
        lat_pat_d   = lat_pat_q;
        on_d        = on_q;
        sseg_d      = '0;
        digit_sel_d = '0;

        case (state_q)
            S_BLANK: begin
                // Pattern and duty are frozen here so the lit window never tears.
                if (cnt_q == 13'(BLANK_CYCLES - 1)) begin
                    state_d   = S_LIT;
                    cnt_d     = '0;
                    lat_pat_d = pat_q[idx_q];
                    on_d      = w_on_cycles;
                end
            end
            S_LIT: begin
                if (cnt_q < on_q) begin
                    sseg_d      = lat_pat_q;
                    digit_sel_d = 16'(1) << idx_q;
                end
                if (cnt_q == C_DWELL - 13'd1) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 4'd1;
                end
            end
            default: begin
                state_d = S_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    assign sseg         = sseg_q;
    assign digit_sel    = digit_sel_q;
    assign avs_readdata = avs_readdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_mux.sv
// +------------------------------------------------------------------+
// | tb_sseg_scan_mux : self-checking bench for sseg_scan_mux          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_sseg_scan_mux;

    localparam int BLANK    = 50;
    localparam int DWELL    = 3125;
    localparam int PERIOD   = BLANK + DWELL;
    localparam int DAY_ON   = (255 * DWELL) / 256;
    localparam int NIGHT_ON = (48 * DWELL) / 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  avs_address = '0;
    logic        avs_chipselect = 1'b0;
    logic        avs_write = 1'b0;
    logic        avs_read = 1'b0;
    logic [7:0]  avs_writedata = '0;
    logic [7:0]  avs_readdata;
    logic        daylight = 1'b1;
    logic [7:0]  sseg;
    logic [15:0] digit_sel;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] mdl_pat [16];
    int         win_on  [40];

    always #10 clk = ~clk;

    sseg_scan_mux dut (
        .clock_50_clk   (clk),
        .reset_reset_n  (rst_n),
        .avs_address    (avs_address),
        .avs_chipselect (avs_chipselect),
        .avs_write      (avs_write),
        .avs_read       (avs_read),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .daylight       (daylight),
        .sseg           (sseg),
        .digit_sel      (digit_sel)
    );

    // Timeline model: digit window k lights at cycle BLANK+1+k*PERIOD for win_on[k] cycles.
    function automatic logic [15:0] exp_sel(int c);
        int t;
        if (c <= BLANK) return '0;
        t = c - BLANK - 1;
        if ((t % PERIOD) < win_on[t / PERIOD]) return 16'(1) << ((t / PERIOD) % 16);
        return '0;
    endfunction

    function automatic logic [7:0] exp_seg(int c);
        int t;
        if (c <= BLANK) return '0;
        t = c - BLANK - 1;
        if ((t % PERIOD) < win_on[t / PERIOD]) return mdl_pat[(t / PERIOD) % 16];
        return '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input logic day);
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
        avs_read       = 1'b0;
        daylight       = day;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 16; i++) mdl_pat[i] = '0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_address    = a;
        avs_writedata  = d;
        step();
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
        if (a < 5'd16) mdl_pat[a[3:0]] = d;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [7:0] q);
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_address    = a;
        step();
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        q = avs_readdata;
    endtask

    task automatic test_reset();
        daylight = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (sseg !== 8'h00) begin n_fail++; $display("FAIL reset_sseg got %h want 00", sseg); end
        n_checks++; if (digit_sel !== 16'h0000) begin n_fail++; $display("FAIL reset_sel got %h want 0000", digit_sel); end
        n_checks++; if (avs_readdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", avs_readdata); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        repeat (BLANK) begin
            step();
            n_checks++;
            if (digit_sel !== 16'h0000) begin n_fail++; $display("FAIL first_gap cyc %0d got %h want 0000", cyc, digit_sel); end
        end
        step();
        n_checks++; if (digit_sel !== 16'h0001) begin n_fail++; $display("FAIL first_digit got %h want 0001", digit_sel); end
        n_checks++; if (sseg !== 8'h00) begin n_fail++; $display("FAIL first_sseg got %h want 00", sseg); end
    endtask

    task automatic test_digit_patterns();
        int toggle, lit0, lit1;
        apply_reset(1'b1);
        for (int k = 0; k < 40; k++) win_on[k] = NIGHT_ON;
        win_on[0] = DAY_ON;
        bus_write(5'd0, 8'h3F);
        bus_write(5'd1, 8'h06);
        toggle = BLANK + 1 + int'($urandom_range(200, 2500));
        lit0 = 0;
        lit1 = 0;
        while (cyc < BLANK + 1 + 2 * PERIOD) begin
            step();
            if (cyc == toggle) daylight = 1'b0;
            n_checks++;
            if (digit_sel !== exp_sel(cyc)) begin n_fail++; $display("FAIL pat_sel cyc %0d got %h want %h", cyc, digit_sel, exp_sel(cyc)); end
            n_checks++;
            if (sseg !== exp_seg(cyc)) begin n_fail++; $display("FAIL pat_sseg cyc %0d got %h want %h", cyc, sseg, exp_seg(cyc)); end
            if (digit_sel == 16'h0001) lit0++;
            if (digit_sel == 16'h0002) lit1++;
        end
        n_checks++; if (lit0 != 3112) begin n_fail++; $display("FAIL day_lit_count got %0d want 3112", lit0); end
        n_checks++; if (lit1 != 585) begin n_fail++; $display("FAIL toggled_night_count got %0d want 585", lit1); end
    endtask

    task automatic test_full_frame();
        int lit [17];
        int t;
        apply_reset(1'b0);
        for (int k = 0; k < 40; k++) win_on[k] = NIGHT_ON;
        for (int k = 0; k < 17; k++) lit[k] = 0;
        for (int i = 0; i < 16; i++) bus_write(5'(i), 8'($urandom));
        while (cyc < BLANK + 1 + 16 * PERIOD + 20) begin
            step();
            n_checks++;
            if (digit_sel !== exp_sel(cyc)) begin n_fail++; $display("FAIL frame_sel cyc %0d got %h want %h", cyc, digit_sel, exp_sel(cyc)); end
            n_checks++;
            if (sseg !== exp_seg(cyc)) begin n_fail++; $display("FAIL frame_sseg cyc %0d got %h want %h", cyc, sseg, exp_seg(cyc)); end
            n_checks++;
            if ($countones(digit_sel) > 1) begin n_fail++; $display("FAIL frame_onehot cyc %0d got %h want at most one bit", cyc, digit_sel); end
            if (cyc == BLANK + 1 + 16 * PERIOD) begin
                n_checks++;
                if (digit_sel !== 16'h0001) begin n_fail++; $display("FAIL frame_wrap got %h want 0001", digit_sel); end
            end
            if (cyc > BLANK && digit_sel != 16'h0000) begin
                t = (cyc - BLANK - 1) / PERIOD;
                if (t < 17) lit[t]++;
            end
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (lit[k] != 585) begin n_fail++; $display("FAIL night_lit digit %0d got %0d want 585", k, lit[k]); end
        end
    endtask

    task automatic test_readback();
        logic [7:0] q, d;
        logic [4:0] a;
        bus_write(5'd7, 8'hA5);
        bus_read(5'd7, q);
        n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL rd_addr7 got %h want a5", q); end
        bus_read(5'd20, q);
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL rd_addr20 got %h want 00", q); end
        for (int i = 0; i < 8; i++) begin
            a = 5'($urandom_range(0, 15));
            d = 8'($urandom);
            bus_write(a, d);
            bus_read(a, q);
            n_checks++;
            if (q !== mdl_pat[a[3:0]]) begin n_fail++; $display("FAIL rd_random addr %0d got %h want %h", a, q, mdl_pat[a[3:0]]); end
        end
        bus_write(5'd3, 8'h12);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b1;
        avs_address = 5'd3; avs_writedata = 8'h34;
        step();
        avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
        n_checks++; if (avs_readdata !== 8'h12) begin n_fail++; $display("FAIL rd_collide got %h want 12", avs_readdata); end
        bus_read(5'd3, q);
        n_checks++; if (q !== 8'h34) begin n_fail++; $display("FAIL rd_after_collide got %h want 34", q); end
        bus_write(5'd25, 8'h77);
        bus_read(5'd25, q);
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL rd_addr25 got %h want 00", q); end
        bus_write(5'd16, 8'h11);
        bus_read(5'd16, q);
`ifdef SSEG_BRIGHTNESS_REG_EN
        n_checks++; if (q !== 8'h11) begin n_fail++; $display("FAIL rd_day_duty got %h want 11", q); end
        bus_read(5'd17, q);
        n_checks++; if (q !== 8'd48) begin n_fail++; $display("FAIL rd_night_duty got %h want 30", q); end
`else
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL rd_day_duty got %h want 00", q); end
        bus_read(5'd17, q);
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL rd_night_duty got %h want 00", q); end
`endif
    endtask

    task automatic test_duty_zero();
        int lit0, want0;
        apply_reset(1'b1);
`ifdef SSEG_BRIGHTNESS_REG_EN
        want0 = 0;
`else
        want0 = DAY_ON;
`endif
        for (int k = 0; k < 40; k++) win_on[k] = want0;
        bus_write(5'd16, 8'h00);
        bus_write(5'd0, 8'hFF);
        lit0 = 0;
        while (cyc < BLANK + 1 + 2 * PERIOD) begin
            step();
            n_checks++;
            if (digit_sel !== exp_sel(cyc)) begin n_fail++; $display("FAIL duty0_sel cyc %0d got %h want %h", cyc, digit_sel, exp_sel(cyc)); end
            n_checks++;
            if (sseg !== exp_seg(cyc)) begin n_fail++; $display("FAIL duty0_sseg cyc %0d got %h want %h", cyc, sseg, exp_seg(cyc)); end
            if (digit_sel == 16'h0001) lit0++;
        end
        n_checks++; if (lit0 != want0) begin n_fail++; $display("FAIL duty0_count got %0d want %0d", lit0, want0); end
    endtask

    task automatic test_reset_mid_lit();
        apply_reset(1'b1);
        for (int k = 0; k < 40; k++) win_on[k] = DAY_ON;
        bus_write(5'd0, 8'h5A);
        while (cyc < BLANK + 1 + 100) step();
        n_checks++; if (digit_sel !== 16'h0001) begin n_fail++; $display("FAIL midlit_pre_sel got %h want 0001", digit_sel); end
        n_checks++; if (sseg !== 8'h5A) begin n_fail++; $display("FAIL midlit_pre_sseg got %h want 5a", sseg); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (digit_sel !== 16'h0000) begin n_fail++; $display("FAIL midlit_async_sel got %h want 0000", digit_sel); end
        n_checks++; if (sseg !== 8'h00) begin n_fail++; $display("FAIL midlit_async_sseg got %h want 00", sseg); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 16; i++) mdl_pat[i] = '0;
        while (cyc < BLANK + 1 + 200) begin
            step();
            n_checks++;
            if (digit_sel !== exp_sel(cyc)) begin n_fail++; $display("FAIL restart_sel cyc %0d got %h want %h", cyc, digit_sel, exp_sel(cyc)); end
            n_checks++;
            if (sseg !== exp_seg(cyc)) begin n_fail++; $display("FAIL restart_sseg cyc %0d got %h want %h", cyc, sseg, exp_seg(cyc)); end
        end
    endtask

    initial begin
        test_reset();
        test_digit_patterns();
        test_full_frame();
        test_readback();
        test_duty_zero();
        test_reset_mid_lit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
